arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width per channel.
REQ-002 SHALL have parameter NCH, default 4, input channel count; legal range 2..16.
REQ-003 SHALL have parameter MODE, default MUX_RR, arbitration mode; one of MUX_SEL, MUX_FIXED, MUX_RR.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, NCH, per-channel request.
REQ-007 SHALL have port in_data, input, NCH x XLEN, per-channel payload.
REQ-008 SHALL have port in_ready, output, NCH, per-channel accept.
REQ-009 SHALL have port sel, input, CHW = max(1, clog2(NCH)), explicit channel select; used only in MUX_SEL.
REQ-010 SHALL have port out_valid, output, 1, output register holds data.
REQ-011 SHALL have port out_data, output, XLEN, registered payload.
REQ-012 SHALL have port out_ch, output, CHW, source channel of out_data.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 SHALL hold one output entry; load_en = in_valid[g] & (~out_valid | out_ready), where g is the granted channel.
REQ-015 SHALL assert in_ready[i] only for i == g and only when (~out_valid | out_ready); at most one in_ready bit high per cycle.
REQ-016 SHALL give latency 1: data accepted in cycle N appears on out_data/out_ch with out_valid in cycle N+1.
REQ-017 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-018 SHALL, with out_valid=1 and out_ready=0, hold out_data/out_ch/out_valid stable and drive in_ready to all zeros.
REQ-019 SHALL clear out_valid after a cycle with out_valid & out_ready & ~load_en.
REQ-020 MUX_SEL: g = sel; sel >= NCH grants no channel (in_ready all 0, no load).
REQ-021 MUX_FIXED: g = lowest-index channel with in_valid set.
REQ-022 MUX_RR: g = first channel with in_valid set, searching from ptr upward and wrapping NCH-1 -> 0.
REQ-023 SHALL update ptr only on load_en, to (g+1) mod NCH; wrap from NCH-1 to 0.
REQ-024 SHALL leave ptr unchanged when no valid is set, or when stalled.
REQ-025 SHALL have grant selection that is combinational from in_valid/ptr/sel; SHALL NOT depend on in_data.
REQ-026 SHALL have a payload that is the value of in_data[g] sampled on the load edge; out_ch = g.

Reset
REQ-027 SHALL, when reset_n is low at a rising clk, set out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-028 SHALL drive in_ready all zeros during any cycle with reset_n low.
REQ-029 SHALL discard the held entry on reset mid-operation; no transfer completes in the reset cycle.

Structure
REQ-030 SHALL place mode constants MUX_SEL/MUX_FIXED/MUX_RR in a mode enum in shared package mux_pkg.
REQ-031 SHALL isolate grant logic (valid vector, ptr, sel, mode -> one-hot grant + index) in sub-module arb_grant.
REQ-032 SHALL keep the output register and ptr in arb_mux.

Verification
REQ-033 SHALL cover RR fairness: NCH=4, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one per cycle after 1-cycle latency.
REQ-034 SHALL cover RR skip/wrap: ptr=3, in_valid=4'b0101 -> grant 0, ptr becomes 1; next cycle grant 2, ptr becomes 3.
REQ-035 SHALL cover backpressure: load data 0xDEADBEEF from ch1, then out_ready=0 for 3 cycles -> out_data stable at 0xDEADBEEF, in_ready=0; then out_ready=1 -> transfer, and a pending request loads the same cycle.
REQ-036 SHALL cover MUX_FIXED starvation: in_valid=4'b1010 held -> out_ch always 1.
REQ-037 SHALL cover MUX_SEL: sel=2 with in_valid=4'b0100 -> out_ch=2; sel=2 with in_valid=4'b0001 -> no load.
REQ-038 SHALL cover mid-stream reset: reset_n low one cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, and RR restarts granting ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrating mux.
package mux_pkg;

    typedef enum logic [1:0] {
        MUX_SEL   = 2'd0,
        MUX_FIXED = 2'd1,
        MUX_RR    = 2'd2
    } mux_mode_e;

    // Channel index width; at least one bit even for a single channel.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection: valid vector, pointer and select -> grant.
module arb_grant
    import mux_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter mux_mode_e   MODE = MUX_RR,
    localparam int unsigned CHW = ch_width(NCH)
) (
    input  logic [NCH-1:0] valid,
    input  logic [CHW-1:0] ptr,
    input  logic [CHW-1:0] sel,
    output logic [NCH-1:0] gnt_oh_c,
    output logic [CHW-1:0] gnt_idx_c,
    output logic           gnt_any_c
);

    // Pick the granted channel; a grant is only reported for a valid channel.
    always_comb begin
        int unsigned idx;
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        idx       = 0;
        case (MODE)
            MUX_SEL: begin
                if ((32'(sel) < NCH) && valid[sel]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = sel;
                end
            end
            MUX_FIXED: begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (!gnt_any_c && valid[CHW'(k)]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = CHW'(k);
                    end
                end
            end
            default: begin
                // Search upward from ptr, wrapping at NCH-1.
                for (int unsigned k = 0; k < NCH; k++) begin
                    idx = (32'(ptr) + k) % NCH;
                    if (!gnt_any_c && valid[CHW'(idx)]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = CHW'(idx);
                    end
                end
            end
        endcase
        if (gnt_any_c) begin
            gnt_oh_c[gnt_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered output entry.
module arb_mux
    import mux_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NCH  = 4,
    parameter mux_mode_e   MODE = MUX_RR,
    localparam int unsigned CHW = ch_width(NCH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH-1:0][XLEN-1:0]  in_data,
    output logic [NCH-1:0]            in_ready,
    input  logic [CHW-1:0]            sel,
    output logic                      out_valid,
    output logic [XLEN-1:0]           out_data,
    output logic [CHW-1:0]            out_ch,
    input  logic                      out_ready
);

    logic [CHW-1:0] ptr;
    logic [NCH-1:0] gnt_oh;
    logic [CHW-1:0] gnt_idx;
    logic           gnt_any;
    logic           can_load;
    logic           load_en;

    arb_grant #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_grant (
        .valid     (in_valid),
        .ptr       (ptr),
        .sel       (sel),
        .gnt_oh_c  (gnt_oh),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // Output slot is free this cycle (empty or draining); never during reset.
    assign can_load = reset_n & (~out_valid | out_ready);
    assign load_en  = can_load & gnt_any;
    assign in_ready = can_load ? gnt_oh : '0;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx];
            out_ch    <= gnt_idx;
            ptr       <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: RR and FIXED at NCH=4, SEL at NCH=5, against a queue-free transfer model.
module tb_arb_mux;
    import mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [3:0]        rr_valid, rr_ready;
    logic [3:0][31:0]  rr_data;
    logic [1:0]        rr_sel, rr_och;
    logic              rr_ov, rr_ordy;
    logic [31:0]       rr_od;

    logic [3:0]        fx_valid, fx_ready;
    logic [3:0][31:0]  fx_data;
    logic [1:0]        fx_sel, fx_och;
    logic              fx_ov, fx_ordy;
    logic [31:0]       fx_od;

    logic [4:0]        sl_valid, sl_ready;
    logic [4:0][31:0]  sl_data;
    logic [2:0]        sl_sel, sl_och;
    logic              sl_ov, sl_ordy;
    logic [31:0]       sl_od;

    arb_mux #(.XLEN(32), .NCH(4), .MODE(MUX_RR)) u_rr (
        .clk(clk), .reset_n(reset_n), .in_valid(rr_valid), .in_data(rr_data),
        .in_ready(rr_ready), .sel(rr_sel), .out_valid(rr_ov), .out_data(rr_od),
        .out_ch(rr_och), .out_ready(rr_ordy));

    arb_mux #(.XLEN(32), .NCH(4), .MODE(MUX_FIXED)) u_fx (
        .clk(clk), .reset_n(reset_n), .in_valid(fx_valid), .in_data(fx_data),
        .in_ready(fx_ready), .sel(fx_sel), .out_valid(fx_ov), .out_data(fx_od),
        .out_ch(fx_och), .out_ready(fx_ordy));

    arb_mux #(.XLEN(32), .NCH(5), .MODE(MUX_SEL)) u_sl (
        .clk(clk), .reset_n(reset_n), .in_valid(sl_valid), .in_data(sl_data),
        .in_ready(sl_ready), .sel(sl_sel), .out_valid(sl_ov), .out_data(sl_od),
        .out_ch(sl_och), .out_ready(sl_ordy));

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 = RR, 1 = FIXED, 2 = SEL.
    logic        m_ov  [3];
    logic [31:0] m_od  [3];
    int          m_och [3];
    int          m_ptr [3];

    function automatic int nch_of(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic logic [15:0] vin(input int d);
        case (d)
            0:       return 16'(rr_valid);
            1:       return 16'(fx_valid);
            default: return 16'(sl_valid);
        endcase
    endfunction

    function automatic logic ordy(input int d);
        case (d)
            0:       return rr_ordy;
            1:       return fx_ordy;
            default: return sl_ordy;
        endcase
    endfunction

    function automatic logic [31:0] din(input int d, input int g);
        case (d)
            0:       return rr_data[2'(g)];
            1:       return fx_data[2'(g)];
            default: return sl_data[3'(g)];
        endcase
    endfunction

    // Granted channel per the mode's rule, or -1 when nothing is granted.
    function automatic int grant_of(input int d);
        logic [15:0] v;
        int n;
        int i;
        v = vin(d);
        n = nch_of(d);
        if (d == 2) begin
            i = int'(sl_sel);
            return (i < n && v[i]) ? i : -1;
        end
        for (int k = 0; k < n; k++) begin
            i = (d == 1) ? k : (m_ptr[d] + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic can_load(input int d);
        return reset_n && (!m_ov[d] || ordy(d));
    endfunction

    function automatic logic [15:0] exp_ready(input int d);
        int g;
        g = grant_of(d);
        return (can_load(d) && g >= 0) ? (16'(1) << g) : 16'(0);
    endfunction

    // Advance one clock, stepping the model with the pre-edge inputs.
    task automatic tick();
        int          g  [3];
        logic        ld [3];
        logic [31:0] dd [3];
        logic        rd [3];
        logic        rst;
        rst = reset_n;
        for (int d = 0; d < 3; d++) begin
            g[d]  = grant_of(d);
            ld[d] = can_load(d) && (g[d] >= 0);
            dd[d] = ld[d] ? din(d, g[d]) : 32'd0;
            rd[d] = ordy(d);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                m_ov[d] = 1'b0; m_od[d] = '0; m_och[d] = 0; m_ptr[d] = 0;
            end else if (ld[d]) begin
                m_ov[d] = 1'b1; m_od[d] = dd[d]; m_och[d] = g[d];
                m_ptr[d] = (g[d] + 1) % nch_of(d);
            end else if (rd[d]) begin
                m_ov[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) begin
            rr_data[i] = $urandom;
            fx_data[i] = $urandom;
        end
        for (int i = 0; i < 5; i++) sl_data[i] = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rr_valid = '1; fx_valid = '1; sl_valid = '1;
        rr_ordy = 1'b1; fx_ordy = 1'b1; sl_ordy = 1'b1;
        rr_sel = '0; fx_sel = '0; sl_sel = '0;
        rand_data();
        #1;
        tests++;
        if (rr_ready !== 4'b0 || fx_ready !== 4'b0 || sl_ready !== 5'b0) begin
            fails++;
            $display("FAIL reset_ready: rr=%b fx=%b sl=%b, want all zero", rr_ready, fx_ready, sl_ready);
        end
        tick();
        tests++;
        if (rr_ov !== 1'b0 || rr_od !== 32'd0 || rr_och !== 2'd0 ||
            fx_ov !== 1'b0 || fx_od !== 32'd0 || fx_och !== 2'd0 ||
            sl_ov !== 1'b0 || sl_od !== 32'd0 || sl_och !== 3'd0) begin
            fails++;
            $display("FAIL reset_out: rr=%b/%h/%0d fx=%b/%h/%0d sl=%b/%h/%0d, want 0/0/0",
                     rr_ov, rr_od, rr_och, fx_ov, fx_od, fx_och, sl_ov, sl_od, sl_och);
        end
        reset_n = 1'b1;
        rr_valid = '0; fx_valid = '0; sl_valid = '0;
    endtask

    task automatic test_rr_fairness();
        logic [31:0] want;
        rr_valid = 4'hf; rr_ordy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            want = rr_data[2'(c % 4)];
            #1;
            tests++;
            if (rr_ready !== 4'(1 << (c % 4))) begin
                fails++;
                $display("FAIL rr_fair_ready[%0d]: got %b want %b", c, rr_ready, 4'(1 << (c % 4)));
            end
            tick();
            tests++;
            if (rr_ov !== 1'b1 || rr_och !== 2'(c % 4) || rr_od !== want) begin
                fails++;
                $display("FAIL rr_fair_out[%0d]: got %b/%0d/%h want 1/%0d/%h", c, rr_ov, rr_och, rr_od, c % 4, want);
            end
        end
        rr_valid = '0;
        tick();
    endtask

    task automatic test_rr_wrap();
        logic [3:0] vseq [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b1001};
        logic [3:0] rseq [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b1000};
        int         cseq [4] = '{2, 0, 2, 3};
        rr_ordy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rr_valid = vseq[c];
            rand_data();
            #1;
            tests++;
            if (rr_ready !== rseq[c]) begin
                fails++;
                $display("FAIL rr_wrap_ready[%0d]: got %b want %b", c, rr_ready, rseq[c]);
            end
            tick();
            tests++;
            if (rr_ov !== 1'b1 || rr_och !== 2'(cseq[c])) begin
                fails++;
                $display("FAIL rr_wrap_ch[%0d]: got %b/%0d want 1/%0d", c, rr_ov, rr_och, cseq[c]);
            end
        end
        rr_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] want;
        rr_ordy = 1'b1; rr_valid = 4'b0010;
        rand_data();
        rr_data[1] = 32'hDEADBEEF;
        tick();
        rr_ordy = 1'b0; rr_valid = 4'hf;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            #1;
            tests++;
            if (rr_ready !== 4'b0) begin
                fails++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, rr_ready);
            end
            tick();
            tests++;
            if (rr_ov !== 1'b1 || rr_od !== 32'hDEADBEEF || rr_och !== 2'd1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got %b/%h/%0d want 1/deadbeef/1", c, rr_ov, rr_od, rr_och);
            end
        end
        rr_ordy = 1'b1;
        rand_data();
        want = rr_data[2];
        #1;
        tests++;
        if (rr_ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 0100", rr_ready);
        end
        tick();
        tests++;
        if (rr_ov !== 1'b1 || rr_od !== want || rr_och !== 2'd2) begin
            fails++;
            $display("FAIL bp_release_out: got %b/%h/%0d want 1/%h/2", rr_ov, rr_od, rr_och, want);
        end
        rr_valid = '0;
        tick();
    endtask

    task automatic test_fixed_starve();
        fx_ordy = 1'b1; fx_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            #1;
            tests++;
            if (fx_ready !== 4'b0010) begin
                fails++;
                $display("FAIL fixed_ready[%0d]: got %b want 0010", c, fx_ready);
            end
            tick();
            tests++;
            if (fx_ov !== 1'b1 || fx_och !== 2'd1 || fx_od !== m_od[1]) begin
                fails++;
                $display("FAIL fixed_out[%0d]: got %b/%0d/%h want 1/1/%h", c, fx_ov, fx_och, fx_od, m_od[1]);
            end
        end
        fx_valid = '0;
        tick();
    endtask

    task automatic test_sel();
        logic [31:0] want;
        sl_ordy = 1'b1; sl_sel = 3'd2; sl_valid = 5'b00100;
        rand_data();
        want = sl_data[2];
        #1;
        tests++;
        if (sl_ready !== 5'b00100) begin
            fails++;
            $display("FAIL sel_ready: got %b want 00100", sl_ready);
        end
        tick();
        tests++;
        if (sl_ov !== 1'b1 || sl_och !== 3'd2 || sl_od !== want) begin
            fails++;
            $display("FAIL sel_out: got %b/%0d/%h want 1/2/%h", sl_ov, sl_och, sl_od, want);
        end
        sl_valid = 5'b00001;
        #1;
        tests++;
        if (sl_ready !== 5'b0) begin
            fails++;
            $display("FAIL sel_noload_ready: got %b want 00000", sl_ready);
        end
        tick();
        tests++;
        if (sl_ov !== 1'b0) begin
            fails++;
            $display("FAIL sel_noload_out: got out_valid %b want 0", sl_ov);
        end
        sl_valid = '1;
        for (int s = 5; s < 8; s++) begin
            sl_sel = 3'(s);
            #1;
            tests++;
            if (sl_ready !== 5'b0) begin
                fails++;
                $display("FAIL sel_range_ready[%0d]: got %b want 00000", s, sl_ready);
            end
            tick();
            tests++;
            if (sl_ov !== 1'b0) begin
                fails++;
                $display("FAIL sel_range_out[%0d]: got out_valid %b want 0", s, sl_ov);
            end
        end
        sl_valid = '0;
    endtask

    task automatic test_mid_reset();
        rr_ordy = 1'b0; rr_valid = 4'b0100;
        rand_data();
        tick();
        reset_n = 1'b0; rr_valid = 4'hf;
        #1;
        tests++;
        if (rr_ov !== 1'b1 || rr_ready !== 4'b0) begin
            fails++;
            $display("FAIL midrst_pre: got ov %b ready %b want 1 / 0000", rr_ov, rr_ready);
        end
        tick();
        tests++;
        if (rr_ov !== 1'b0 || rr_od !== 32'd0 || rr_och !== 2'd0) begin
            fails++;
            $display("FAIL midrst_out: got %b/%h/%0d want 0/0/0", rr_ov, rr_od, rr_och);
        end
        reset_n = 1'b1; rr_ordy = 1'b1;
        #1;
        tests++;
        if (rr_ready !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_restart_ready: got %b want 0001", rr_ready);
        end
        tick();
        tests++;
        if (rr_ov !== 1'b1 || rr_och !== 2'd0) begin
            fails++;
            $display("FAIL midrst_restart_out: got %b/%0d want 1/0", rr_ov, rr_och);
        end
        rr_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n  = ($urandom_range(0, 39) != 0);
            rr_valid = 4'($urandom); fx_valid = 4'($urandom); sl_valid = 5'($urandom);
            rr_ordy  = ($urandom_range(0, 3) != 0);
            fx_ordy  = ($urandom_range(0, 3) != 0);
            sl_ordy  = ($urandom_range(0, 3) != 0);
            sl_sel   = 3'($urandom_range(0, 7));
            rand_data();
            #1;
            tests++;
            if (16'(rr_ready) !== exp_ready(0) || 16'(fx_ready) !== exp_ready(1) ||
                16'(sl_ready) !== exp_ready(2)) begin
                fails++;
                $display("FAIL rand_ready[%0d]: rr=%b/%h fx=%b/%h sl=%b/%h", c,
                         rr_ready, exp_ready(0), fx_ready, exp_ready(1), sl_ready, exp_ready(2));
            end
            tick();
            tests++;
            if (rr_ov !== m_ov[0] || rr_od !== m_od[0] || rr_och !== 2'(m_och[0])) begin
                fails++;
                $display("FAIL rand_rr[%0d]: got %b/%h/%0d want %b/%h/%0d", c,
                         rr_ov, rr_od, rr_och, m_ov[0], m_od[0], m_och[0]);
            end
            tests++;
            if (fx_ov !== m_ov[1] || fx_od !== m_od[1] || fx_och !== 2'(m_och[1])) begin
                fails++;
                $display("FAIL rand_fx[%0d]: got %b/%h/%0d want %b/%h/%0d", c,
                         fx_ov, fx_od, fx_och, m_ov[1], m_od[1], m_och[1]);
            end
            tests++;
            if (sl_ov !== m_ov[2] || sl_od !== m_od[2] || sl_och !== 3'(m_och[2])) begin
                fails++;
                $display("FAIL rand_sl[%0d]: got %b/%h/%0d want %b/%h/%0d", c,
                         sl_ov, sl_od, sl_och, m_ov[2], m_od[2], m_och[2]);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_ov[d] = 1'b0; m_od[d] = '0; m_och[d] = 0; m_ptr[d] = 0;
        end
        test_reset();
        test_rr_fairness();
        test_rr_wrap();
        test_back_pressure();
        test_fixed_starve();
        test_sel();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
